// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: machine width, register index type and the x0 index.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/reg_file_if.sv
// Writeback bus into the register file; read ports snoop it for same-cycle bypass.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output en, output addr, output data);
  modport slave  (input  en, input  addr, input  data);

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: x0 masking, writeback bypass and reset forcing.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int NREGS     = NUM_REGS,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              rst_n,
  reg_file_if.slave         wr,
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] regs [1:NREGS-1],
  output logic [DATA_W-1:0] data
);

  // NOTE: assigning a default before any branch keeps every path driven, so no latch is inferred.
  always_comb begin
    data = '0;
    if (rst_n && rs != '0) begin
      if (BYPASS_EN && wr.en && wr.addr == rs) begin
        data = wr.data;
      end else begin
        data = regs[rs];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: 31 stored registers (x0 reads zero), two async read
// ports with optional writeback bypass, one synchronous write port.
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int NREGS     = 2 ** ADDR_W,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] Write_data_i,
  input  logic              RegWriteE_i,
  input  logic [ADDR_W-1:0] Rd_i,
  input  logic [ADDR_W-1:0] Rs1_i,
  input  logic [ADDR_W-1:0] Rs2_i,
  output logic [DATA_W-1:0] Read_reg1_o,
  output logic [DATA_W-1:0] Read_reg2_o
);

  logic [DATA_W-1:0] regs [1:NREGS-1];

  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_bus ();

  assign wr_bus.en   = RegWriteE_i;
  assign wr_bus.addr = Rd_i;
  assign wr_bus.data = Write_data_i;

  // NOTE: the array is cleared by reset because software may read a register before writing it;
  // sequential state always uses non-blocking assignment so all reads see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWriteE_i && Rd_i != '0) begin
      regs[Rd_i] <= Write_data_i;
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .BYPASS_EN(BYPASS_EN)
  ) u_read1 (
    .rst_n (rst_i),
    .wr    (wr_bus.slave),
    .rs    (Rs1_i),
    .regs  (regs),
    .data  (Read_reg1_o)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .BYPASS_EN(BYPASS_EN)
  ) u_read2 (
    .rst_n (rst_i),
    .wr    (wr_bus.slave),
    .rs    (Rs2_i),
    .regs  (regs),
    .data  (Read_reg2_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file;
  import riscv_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t rs1, rs2;
  word_t     rd1, rd2;

  reg_file_if #(.DATA_W(XLEN), .ADDR_W(REG_ADDR_W)) bus ();

  always #5 clk = ~clk;

  reg_file dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .Write_data_i (bus.data),
    .RegWriteE_i  (bus.en),
    .Rd_i         (bus.addr),
    .Rs1_i        (rs1),
    .Rs2_i        (rs2),
    .Read_reg1_o  (rd1),
    .Read_reg2_o  (rd2)
  );

  word_t model [NUM_REGS];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // What a read port should show right now, from the architectural rules.
  function automatic word_t expect_read(input reg_addr_t rs);
    if (!rst)                               return '0;
    if (rs == X0)                           return '0;
    if (bus.en && bus.addr == rs)           return bus.data;
    return model[rs];
  endfunction

  // Advance one rising edge, commit the model from the pre-edge inputs, land 1 unit after.
  task automatic edge_step();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (bus.en && bus.addr != X0) begin
      model[bus.addr] = bus.data;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = 'x;
    rst = 1'b0; bus.en = 1'b0; bus.addr = '0; bus.data = '0; rs1 = 5'd7; rs2 = 5'd9;

    // Reset held for two edges; outputs forced to zero meanwhile.
    edge_step();
    check("rst_hold_rd1", rd1, 32'h0);
    edge_step();
    check("rst_hold_rd2", rd2, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      rs1 = reg_addr_t'(i);
      rs2 = reg_addr_t'(31 - i);
      #1;
      check("rst_sweep_rd1", rd1, 32'h0);
      check("rst_sweep_rd2", rd2, 32'h0);
    end
    edge_step();

    // Basic write then read, with retention.
    bus.en = 1'b1; bus.addr = 5'd1; bus.data = 32'hDEADBEEF;
    edge_step();
    bus.en = 1'b0; rs1 = 5'd1;
    #1;
    check("wr_rd1", rd1, 32'hDEADBEEF);
    repeat (5) edge_step();
    check("wr_retain", rd1, 32'hDEADBEEF);

    // Same-cycle bypass on both ports, sampled 1 unit before the edge.
    bus.en = 1'b1; bus.addr = 5'd5; bus.data = 32'h12345678; rs1 = 5'd5; rs2 = 5'd5;
    #8;
    check("bypass_rd1", rd1, 32'h12345678);
    check("bypass_rd2", rd2, 32'h12345678);
    edge_step();
    bus.en = 1'b0;
    #1;
    check("bypass_stored", rd1, 32'h12345678);

    // x0 writes are discarded.
    bus.en = 1'b1; bus.addr = 5'd0; bus.data = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd1;
    #1;
    check("x0_pre", rd1, 32'h0);
    check("x0_reg1_pre", rd2, 32'hDEADBEEF);
    edge_step();
    bus.en = 1'b0;
    #1;
    check("x0_post", rd1, 32'h0);
    check("x0_reg1_post", rd2, 32'hDEADBEEF);

    // Reset wins over a simultaneous write.
    rst = 1'b0; bus.en = 1'b1; bus.addr = 5'd3; bus.data = 32'hA5A5A5A5; rs1 = 5'd3; rs2 = 5'd1;
    #1;
    check("rstw_force_rd1", rd1, 32'h0);
    check("rstw_force_rd2", rd2, 32'h0);
    edge_step();
    rst = 1'b1; bus.en = 1'b0;
    #1;
    check("rstw_reg3", rd1, 32'h0);
    check("rstw_reg1_cleared", rd2, 32'h0);

    // Fill every register, then read two different indices per step.
    for (int k = 1; k < NUM_REGS; k++) begin
      bus.en = 1'b1; bus.addr = reg_addr_t'(k); bus.data = 32'h100 + k;
      edge_step();
    end
    bus.en = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rs1 = reg_addr_t'(k);
      rs2 = reg_addr_t'(31 - k);
      #1;
      check("dual_rd1", rd1, (k == 0)  ? 32'h0 : 32'h100 + k);
      check("dual_rd2", rd2, (k == 31) ? 32'h0 : 32'h100 + (31 - k));
    end
    edge_step();

    // Randomized traffic against the model; read indices often collide with rd.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 24) != 0);
      bus.en   = $urandom_range(0, 1) == 1;
      bus.addr = reg_addr_t'($urandom_range(0, 31));
      bus.data = $urandom;
      rs1      = ($urandom_range(0, 3) == 0) ? bus.addr : reg_addr_t'($urandom_range(0, 31));
      rs2      = ($urandom_range(0, 3) == 0) ? bus.addr : reg_addr_t'($urandom_range(0, 31));
      #8;
      check("rand_rd1", rd1, expect_read(rs1));
      check("rand_rd2", rd2, expect_read(rs2));
      edge_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
